// File: rtl/mem_access_unit_if.sv
// Request/response and memory-port bundle for mem_access_unit.
// master: the access unit itself; slave: datapath control plus memory.
// Optional MEM_ALIGN_CHECK_EN adds the fault response bit.
interface mem_access_unit_if #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MAX_IND = 2
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IND_W = $clog2(MAX_IND + 1);

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic [IND_W-1:0]  req_indirect;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_byte_enable;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
`ifdef MEM_ALIGN_CHECK_EN
    logic              fault;
`endif

    modport master (
`ifdef MEM_ALIGN_CHECK_EN
        output fault,
`endif
        input  req_valid, req_write, req_byte, req_indirect, req_addr, req_wdata,
        input  mem_rdata, mem_resp,
        output req_ready, mem_address, mem_wdata, mem_byte_enable, mem_read, mem_write,
        output rsp_valid, rsp_rdata, busy
    );

    modport slave (
`ifdef MEM_ALIGN_CHECK_EN
        input  fault,
`endif
        output req_valid, req_write, req_byte, req_indirect, req_addr, req_wdata,
        output mem_rdata, mem_resp,
        input  req_ready, mem_address, mem_wdata, mem_byte_enable, mem_read, mem_write,
        input  rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store access unit: runs one LDR/STR/LDB/STB/LDI/STI access per request,
// following up to MAX_IND pointer levels, with byte-lane select/replicate.
// Optional MEM_ALIGN_CHECK_EN: misaligned word/pointer accesses end with fault=1
// instead of being silently aligned.
module mem_access_unit #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned MAX_IND = 2
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.master bus
);
    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(BE_W);
    localparam int unsigned IND_W  = $clog2(MAX_IND + 1);

    typedef enum logic [2:0] {StIdle, StInd, StAccRd, StAccWr, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic [IND_W-1:0]  ind_cnt_q, ind_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic [LANE_W-1:0] lane;
    logic [7:0]        byte_sel;
    logic [IND_W-1:0]  ind_clamped;
    logic              align_fault;
    state_e            acc_state;

    assign lane        = addr_q[LANE_W-1:0];
    assign byte_sel    = bus.mem_rdata[{lane, 3'b000} +: 8];
    assign ind_clamped = (bus.req_indirect > IND_W'(MAX_IND)) ? IND_W'(MAX_IND)
                                                               : bus.req_indirect;
    assign acc_state   = write_q ? StAccWr : StAccRd;

`ifdef MEM_ALIGN_CHECK_EN
    // Pointer reads are always full-word; final accesses only matter for words.
    assign align_fault = (addr_q[LANE_W-1:0] != '0) &&
                         ((state_q == StInd) ||
                          (((state_q == StAccRd) || (state_q == StAccWr)) && !byte_q));
    assign bus.fault   = fault_q;
`else
    assign align_fault = 1'b0;
`endif

    // State and transaction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            byte_q    <= 1'b0;
            ind_cnt_q <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            byte_q    <= byte_d;
            ind_cnt_q <= ind_cnt_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
        end
    end

    // Next-state: accept, pointer chase, final access, completion
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        byte_d    = byte_q;
        ind_cnt_d = ind_cnt_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d    = bus.req_addr;
                    wdata_d   = bus.req_wdata;
                    write_d   = bus.req_write;
                    byte_d    = bus.req_byte;
                    ind_cnt_d = ind_clamped;
                    rdata_d   = '0;
                    fault_d   = 1'b0;
                    if (ind_clamped != '0) begin
                        state_d = StInd;
                    end else begin
                        state_d = bus.req_write ? StAccWr : StAccRd;
                    end
                end
            end
            StInd: begin
                if (align_fault) begin
                    fault_d = 1'b1;
                    state_d = StDone;
                end else if (bus.mem_resp) begin
                    addr_d    = ADDR_W'(bus.mem_rdata);
                    ind_cnt_d = ind_cnt_q - IND_W'(1);
                    if (ind_cnt_q == IND_W'(1)) begin
                        state_d = acc_state;
                    end
                end
            end
            StAccRd: begin
                if (align_fault) begin
                    fault_d = 1'b1;
                    state_d = StDone;
                end else if (bus.mem_resp) begin
                    rdata_d = byte_q ? DATA_W'(byte_sel) : bus.mem_rdata;
                    state_d = StDone;
                end
            end
            StAccWr: begin
                if (align_fault) begin
                    fault_d = 1'b1;
                    state_d = StDone;
                end else if (bus.mem_resp) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs; bus fields are zero whenever no strobe is active
    always_comb begin
        bus.mem_address     = '0;
        bus.mem_wdata       = '0;
        bus.mem_byte_enable = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        if (((state_q == StInd) || (state_q == StAccRd) || (state_q == StAccWr)) &&
            !align_fault) begin
            bus.mem_address     = {addr_q[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            bus.mem_byte_enable = ((state_q == StInd) || !byte_q) ? {BE_W{1'b1}}
                                                                   : BE_W'(1) << lane;
            bus.mem_read        = (state_q != StAccWr);
            bus.mem_write       = (state_q == StAccWr);
            if (state_q == StAccWr) begin
                bus.mem_wdata = byte_q ? {BE_W{wdata_q[7:0]}} : wdata_q;
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus randomized traffic
// against a transaction-level model of the access rules.
`timescale 1ns/1ps
module tb_mem_access_unit;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int MI = 2;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(DW), .ADDR_W(AW), .MAX_IND(MI)) bus ();
    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .MAX_IND(MI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;
    typedef struct packed {
        logic [15:0] rdata;
        logic        fault;
    } rsp_t;

    acc_t        acc_q[$];
    rsp_t        rsp_q[$];
    logic [15:0] mem[0:255];
    int          checks = 0;
    int          errors = 0;
    int          fixed_delay = -1;
    int          rd_cycles = 0;
    int          wcnt = -1;

    function automatic int idx(input logic [15:0] a);
        return int'(a[8:1]);
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: expected bus accesses and response for one request
    function automatic void model(input logic w, input logic b, input logic [1:0] ind,
                                  input logic [15:0] a0, input logic [15:0] wd);
        logic [15:0] a;
        logic [15:0] word;
        int          n;
        bit          flt;
        acc_t        e;
        rsp_t        r;
        a   = a0;
        n   = (ind > 2) ? 2 : int'(ind);
        flt = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (ALIGN && a[0]) begin
                flt = 1'b1;
                break;
            end
            e.wr = 1'b0; e.addr = {a[15:1], 1'b0}; e.be = 2'b11; e.wdata = '0;
            acc_q.push_back(e);
            a = mem[idx(a)];
        end
        r.rdata = '0;
        if (!flt) begin
            if (!b && ALIGN && a[0]) begin
                flt = 1'b1;
            end else begin
                e.wr    = w;
                e.addr  = {a[15:1], 1'b0};
                e.be    = b ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
                e.wdata = w ? (b ? {wd[7:0], wd[7:0]} : wd) : 16'h0;
                acc_q.push_back(e);
                if (!w) begin
                    word    = mem[idx(a)];
                    r.rdata = b ? {8'h00, (a[0] ? word[15:8] : word[7:0])} : word;
                end
            end
        end
        r.fault = flt;
        rsp_q.push_back(r);
    endfunction

    // Memory responder: checks each access against the scoreboard, then answers
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_resp = 1'b0;
            wcnt = -1;
        end else begin
            acc_t e;
            if (bus.mem_read) rd_cycles++;
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 16'($urandom);
            if (bus.mem_read || bus.mem_write) begin
                if (wcnt < 0) begin
                    wcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_access: addr %0h seen, none expected",
                                 bus.mem_address);
                    end else begin
                        e = acc_q.pop_front();
                        check("acc_write", 32'(bus.mem_write), 32'(e.wr));
                        check("acc_addr", 32'(bus.mem_address), 32'(e.addr));
                        check("acc_be", 32'(bus.mem_byte_enable), 32'(e.be));
                        if (e.wr) check("acc_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                    end
                end
                if (wcnt == 0) begin
                    if (bus.mem_write) begin
                        if (bus.mem_byte_enable[0])
                            mem[idx(bus.mem_address)][7:0] = bus.mem_wdata[7:0];
                        if (bus.mem_byte_enable[1])
                            mem[idx(bus.mem_address)][15:8] = bus.mem_wdata[15:8];
                    end else begin
                        bus.mem_rdata = mem[idx(bus.mem_address)];
                    end
                    bus.mem_resp = 1'b1;
                    wcnt = -1;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            rsp_t r;
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rdata %0h, none expected", bus.rsp_rdata);
            end else begin
                r = rsp_q.pop_front();
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
`ifdef MEM_ALIGN_CHECK_EN
                check("rsp_fault", 32'(bus.fault), 32'(r.fault));
`endif
            end
        end
    end

    task automatic drive_req(input logic w, input logic b, input logic [1:0] ind,
                             input logic [15:0] a, input logic [15:0] wd);
        int guard;
        model(w, b, ind, a, wd);
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_byte     = b;
        bus.req_indirect = ind;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    // lat counts edges from the accept edge through the edge raising rsp_valid
    task automatic issue(input logic w, input logic b, input logic [1:0] ind,
                         input logic [15:0] a, input logic [15:0] wd, output int lat);
        drive_req(w, b, ind, a, wd);
        lat = 1;
        forever begin
            @(posedge clk);
            lat++;
            #1;
            if (bus.rsp_valid) break;
            if (lat >= 60) begin
                checks++;
                errors++;
                $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", lat);
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int lat;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_byte     = 1'b0;
        bus.req_indirect = '0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_resp     = 1'b0;
        bus.mem_rdata    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);

        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_mem_address", 32'(bus.mem_address), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_mem_be", 32'(bus.mem_byte_enable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word load with mem_resp in the third strobe cycle
        mem[idx(16'h3000)] = 16'hBEEF;
        fixed_delay = 2;
        rd_cycles = 0;
        issue(1'b0, 1'b0, 2'd0, 16'h3000, 16'h0, lat);
        check("t1_read_cycles", 32'(rd_cycles), 32'd3);
        check("t1_latency", 32'(lat), 32'd4);
        fixed_delay = -1;

        // Byte load upper lane, byte store lower lane
        mem[idx(16'h3000)] = 16'hA55A;
        issue(1'b0, 1'b1, 2'd0, 16'h3001, 16'h0, lat);
        issue(1'b1, 1'b1, 2'd0, 16'h4000, 16'h12CD, lat);

        // Indirect load, then over-range level count clamped to two pointer reads
        mem[idx(16'h5000)] = 16'h6002;
        mem[idx(16'h6002)] = 16'h1234;
        mem[idx(16'h1234)] = 16'h7777;
        issue(1'b0, 1'b0, 2'd1, 16'h5000, 16'h0, lat);
        issue(1'b0, 1'b0, 2'd3, 16'h5000, 16'h0, lat);

        // Minimum latency with immediate response
        fixed_delay = 0;
        issue(1'b0, 1'b0, 2'd0, 16'h3000, 16'h0, lat);
        check("min_latency", 32'(lat), 32'd2);
        fixed_delay = -1;

        // Misaligned word load: fault under the check, silently aligned otherwise
        issue(1'b0, 1'b0, 2'd0, 16'h3001, 16'h0, lat);
`ifdef MEM_ALIGN_CHECK_EN
        check("t6_fault_latency", 32'(lat), 32'd2);
`endif

        // Reset during ACC_RD aborts without a response
        fixed_delay = 6;
        drive_req(1'b0, 1'b0, 2'd0, 16'h3000, 16'h0);
        @(posedge clk);
        #1;
        check("t5_read_before_rst", 32'(bus.mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_read_drops", 32'(bus.mem_read), 32'd0);
        check("t5_busy_drops", 32'(bus.busy), 32'd0);
        acc_q.delete();
        rsp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fixed_delay = -1;
        @(negedge clk);
        check("t5_ready_after_rst", 32'(bus.req_ready), 32'd1);
        issue(1'b0, 1'b0, 2'd0, 16'h3000, 16'h0, lat);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            issue(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom), lat);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(rsp_q.size() + acc_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
